// File: rtl/instr_fetch.sv
// Instruction fetch stage: turns PC update strobes into single outstanding
// instruction-memory reads and hands the result to decode over valid/ready.
module instr_fetch #(
  parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
  parameter int          IMEM_WORDS = 1024,
  parameter int          MADDR_W    = 10,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic               pc_update,
  output logic               mem_en,
  output logic [MADDR_W-1:0] mem_addr,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_rvalid,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fault,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  // NOTE: the end address is formed in 33 bits so a base near the top of the
  // address space cannot wrap and make every PC look in range.
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

  state_t      state, state_nxt;
  logic [31:0] cur_pc;
  logic [31:0] pend_pc;
  logic        pend_v;
  logic        stale;

  logic        start;
  logic [31:0] start_pc;
  logic        start_bad;
  logic        drop_rsp;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IMEM_BASE) || ({1'b0, a} >= IMEM_END);
  endfunction

  // A fresh strobe in IDLE beats any parked redirect.
  assign start     = pc_update || pend_v;
  assign start_pc  = pc_update ? addr : pend_pc;
  assign start_bad = addr_bad(start_pc);
  // A response is useless if a redirect happened earlier or lands this cycle.
  assign drop_rsp  = stale || pc_update;

  // NOTE: asynchronous reset with non-blocking assignments for all state;
  // blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = start_bad ? S_HOLD : S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid) state_nxt = drop_rsp ? S_IDLE : S_HOLD;
      S_HOLD: if (pc_update || instr_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en = (state == S_REQ);
    busy   = (state != S_IDLE) || pend_v;
  end

  assign mem_addr = MADDR_W'((cur_pc - IMEM_BASE) >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_pc      <= IMEM_BASE;
      pend_pc     <= IMEM_BASE;
      pend_v      <= 1'b0;
      stale       <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= IMEM_BASE;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      // Redirect outside IDLE: park the newest PC.
      if (pc_update && state != S_IDLE) begin
        pend_pc <= addr;
        pend_v  <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur_pc <= start_pc;
            pend_v <= 1'b0;
            if (start_bad) begin
              instr       <= NOP_INSTR;
              instr_pc    <= start_pc;
              fault       <= 1'b1;
              instr_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (pc_update) stale <= 1'b1;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (drop_rsp) begin
              stale <= 1'b0;
            end else begin
              instr       <= mem_rdata;
              instr_pc    <= cur_pc;
              fault       <= 1'b0;
              instr_valid <= 1'b1;
            end
          end else if (pc_update) begin
            stale <= 1'b1;
          end
        end
        S_HOLD: begin
          // Withdraw on redirect even if decode is ready this same cycle.
          if (pc_update || instr_ready) instr_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, normal fetch, stall, faults,
// redirects during WAIT and HOLD, and reset in the middle of a fetch.
module tb_instr_fetch;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        pc_update = 1'b0;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fault;
  logic        busy;

  logic        auto_rvalid = 1'b0;
  logic        man_rvalid  = 1'b0;
  logic        auto_resp   = 1'b1;
  int          rlat        = 1;
  logic [31:0] resp_data   = '0;
  logic [31:0] resp_q      = '0;
  int          en_cnt      = 0;
  logic [9:0]  last_maddr  = '0;
  logic        seen_dead   = 1'b0;

  int vectors = 0;
  int errs    = 0;

  assign mem_rvalid = auto_rvalid | man_rvalid;

  instr_fetch dut (
    .clk(clk), .rst(rst), .addr(addr), .pc_update(pc_update),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: answers each request after rlat cycles with resp_data
  // captured at request time.
  always begin
    @(negedge clk);
    if (mem_en) begin
      en_cnt++;
      last_maddr = mem_addr;
    end
    if (mem_en && auto_resp) begin
      resp_q = resp_data;
      repeat (rlat) @(posedge clk);
      #1;
      auto_rvalid = 1'b1;
      mem_rdata   = resp_q;
      @(posedge clk);
      #1 auto_rvalid = 1'b0;
    end
  end

  always @(negedge clk)
    if (instr_valid && instr == 32'hDEAD_BEEF) seen_dead = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] a);
    addr      = a;
    pc_update = 1'b1;
    tick();
    pc_update = 1'b0;
  endtask

  task automatic ack();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (instr_valid) ok = 1'b1;
      else tick();
    end
  endtask

  initial begin
    int  cnt0;
    bit  ok;

    // Reset values
    tick();
    tick();
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, BASE);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();

    // Minimum-latency fetch at the base address
    resp_data = 32'h0050_0093;
    pulse(BASE);
    check("t1_mem_en", 32'(mem_en), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    check("t1_valid_c2", 32'(instr_valid), 32'd0);
    tick();
    check("t1_valid_c3", 32'(instr_valid), 32'd1);
    check("t1_instr", instr, 32'h0050_0093);
    check("t1_instr_pc", instr_pc, BASE);
    check("t1_fault", 32'(fault), 32'd0);
    ack();
    check("t1_valid_drop", 32'(instr_valid), 32'd0);

    // Decoder stall: outputs held stable
    resp_data = 32'h1234_5678;
    pulse(32'h0100_0008);
    check("t2_mem_addr", 32'(mem_addr), 32'd2);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(instr_valid), 32'd1);
      check("t2_hold_instr", instr, 32'h1234_5678);
      check("t2_hold_pc", instr_pc, 32'h0100_0008);
      tick();
    end
    instr_ready = 1'b1;
    check("t2_valid_at_ready", 32'(instr_valid), 32'd1);
    tick();
    instr_ready = 1'b0;
    check("t2_valid_after_ready", 32'(instr_valid), 32'd0);

    // Faulting addresses: misaligned, one past end, below base
    cnt0 = en_cnt;
    pulse(32'h0100_0002);
    check("t3a_valid", 32'(instr_valid), 32'd1);
    check("t3a_fault", 32'(fault), 32'd1);
    check("t3a_instr", instr, NOP);
    check("t3a_mem_en", 32'(mem_en), 32'd0);
    ack();
    pulse(32'h0100_1000);
    check("t3b_valid", 32'(instr_valid), 32'd1);
    check("t3b_fault", 32'(fault), 32'd1);
    check("t3b_instr", instr, NOP);
    ack();
    pulse(32'h00FF_FFFC);
    check("t3c_fault", 32'(fault), 32'd1);
    check("t3c_valid", 32'(instr_valid), 32'd1);
    ack();
    check("t3_no_mem_en", 32'(en_cnt), 32'(cnt0));

    // Redirect during WAIT drops the in-flight response
    rlat      = 3;
    resp_data = 32'hDEAD_BEEF;
    cnt0      = en_cnt;
    pulse(32'h0100_0010);
    tick();
    pulse(32'h0100_0040);
    resp_data = 32'hCAFE_0001;
    wait_valid(30, ok);
    check("t4_valid_seen", 32'(ok), 32'd1);
    check("t4_no_deadbeef", 32'(seen_dead), 32'd0);
    check("t4_mem_en_count", 32'(en_cnt), 32'(cnt0 + 2));
    check("t4_mem_addr", 32'(last_maddr), 32'd16);
    check("t4_instr", instr, 32'hCAFE_0001);
    check("t4_instr_pc", instr_pc, 32'h0100_0040);
    check("t4_fault", 32'(fault), 32'd0);
    ack();

    // Two redirects during one WAIT: newest wins, one further request
    rlat      = 4;
    resp_data = 32'hAAAA_0000;
    cnt0      = en_cnt;
    pulse(32'h0100_0010);
    tick();
    resp_data = 32'hBBBB_0000;
    pulse(32'h0100_0020);
    pulse(32'h0100_0030);
    wait_valid(40, ok);
    check("t5_valid_seen", 32'(ok), 32'd1);
    check("t5_mem_en_count", 32'(en_cnt), 32'(cnt0 + 2));
    check("t5_mem_addr", 32'(last_maddr), 32'd12);
    check("t5_instr_pc", instr_pc, 32'h0100_0030);
    check("t5_instr", instr, 32'hBBBB_0000);

    // Redirect in HOLD with ready high the same cycle withdraws the word
    rlat        = 1;
    resp_data   = 32'hCCCC_0004;
    instr_ready = 1'b1;
    pulse(32'h0100_0004);
    instr_ready = 1'b0;
    check("t6_withdrawn", 32'(instr_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    wait_valid(20, ok);
    check("t6_valid_seen", 32'(ok), 32'd1);
    check("t6_instr_pc", instr_pc, 32'h0100_0004);
    check("t6_instr", instr, 32'hCCCC_0004);
    ack();

    // Reset in WAIT, then a late response
    auto_resp = 1'b0;
    pulse(32'h0100_0014);
    tick();
    rst = 1'b0;
    #1;
    check("t7_rst_mem_en", 32'(mem_en), 32'd0);
    check("t7_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("t7_rst_instr", instr, NOP);
    check("t7_rst_instr_pc", instr_pc, BASE);
    check("t7_rst_valid", 32'(instr_valid), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    tick();
    rst        = 1'b1;
    man_rvalid = 1'b1;
    tick();
    man_rvalid = 1'b0;
    check("t7_late_valid", 32'(instr_valid), 32'd0);
    tick();
    tick();
    check("t7_late_valid2", 32'(instr_valid), 32'd0);
    check("t7_late_busy", 32'(busy), 32'd0);
    auto_resp = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
